// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
// sap_pkg : opcodes, FSM state encodings and flag indices for the SAP core
// Rev 1.0
// ============================================================================
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sap_regfile.sv
`default_nettype none
// ============================================================================
// sap_regfile : NUM_REGS x DATA_W register file, one write port, two read ports
// Rev 1.0
// ============================================================================
module sap_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int RSEL_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RSEL_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RSEL_W-1:0] raddr_r,
  output logic [DATA_W-1:0] rdata_r,
  input  logic [RSEL_W-1:0] raddr_out,
  output logic [DATA_W-1:0] rdata_out
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    always_comb regs_d[i] = (we && (waddr == RSEL_W'(i))) ? wdata : regs_q[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) regs_q[i] <= '0;
      else     regs_q[i] <= regs_d[i];
    end
  end

  assign rdata_r   = regs_q[raddr_r];
  assign rdata_out = regs_q[raddr_out];

endmodule
`default_nettype wire

// File: rtl/sap_core_param.sv
`default_nettype none
// ============================================================================
// sap_core_param : multicycle SAP core, NUM_REGS registers, req/ready memory port
// Rev 1.0
// ============================================================================
module sap_core_param
  import sap_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc,
  output logic [2:0]        dbg_state
);

  localparam int RSEL_W = $clog2(NUM_REGS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        ir_op_q, ir_op_d;
  logic [RSEL_W-1:0] ir_r_q, ir_r_d;
  logic [ADDR_W-1:0] ir_opnd_q, ir_opnd_d;
  logic [1:0]        flags_q, flags_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              halted_q, halted_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rd_r, rd_out;
  logic [DATA_W:0]   sum, diff;

  sap_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RSEL_W   (RSEL_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we        (rf_we),
    .waddr     (ir_r_q),
    .wdata     (rf_wdata),
    .raddr_r   (ir_r_q),
    .rdata_r   (rd_r),
    .raddr_out (ir_r_q),
    .rdata_out (rd_out)
  );

  // MSB of the DATA_W+1 result is carry on ADD and borrow on SUB
  assign sum  = {1'b0, rd_r} + {1'b0, mem_rdata};
  assign diff = {1'b0, rd_r} - {1'b0, mem_rdata};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_op_d     = ir_op_q;
    ir_r_d      = ir_r_q;
    ir_opnd_d   = ir_opnd_q;
    flags_d     = flags_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    rf_we       = 1'b0;
    rf_wdata    = '0;

    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          ir_op_d   = mem_rdata[DATA_W-1 -: 4];
          ir_r_d    = mem_rdata[DATA_W-5 -: RSEL_W];
          ir_opnd_d = mem_rdata[ADDR_W-1:0];
          pc_d      = pc_q + 1'b1;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (ir_op_q)
          OP_LDI: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(ir_opnd_q);
          end
          OP_JMP: pc_d = ir_opnd_q;
          OP_JZ:  if (flags_q[FLAG_Z]) pc_d = ir_opnd_q;
          OP_JC:  if (flags_q[FLAG_C]) pc_d = ir_opnd_q;
          OP_OUT: begin
            out_data_d  = rd_out;
            out_valid_d = 1'b1;
          end
          OP_HLT: state_d = ST_HALT;
          default: if (is_mem_op(ir_op_q)) state_d = ST_MEM;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
          case (ir_op_q)
            OP_LDA: begin
              rf_we    = 1'b1;
              rf_wdata = mem_rdata;
            end
            OP_ADD: begin
              rf_we           = 1'b1;
              rf_wdata        = sum[DATA_W-1:0];
              flags_d[FLAG_Z] = (sum[DATA_W-1:0] == '0);
              flags_d[FLAG_C] = sum[DATA_W];
            end
            OP_SUB: begin
              rf_we           = 1'b1;
              rf_wdata        = diff[DATA_W-1:0];
              flags_d[FLAG_Z] = (diff[DATA_W-1:0] == '0);
              flags_d[FLAG_C] = diff[DATA_W];
            end
            default: ;
          endcase
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_START;
    endcase

    // Port outputs are registered from the next state so they are glitch-free
    mem_req_d   = (state_d == ST_FETCH) || (state_d == ST_MEM);
    mem_we_d    = (state_d == ST_MEM) && (ir_op_d == OP_STA);
    mem_addr_d  = (state_d == ST_MEM) ? ir_opnd_d : pc_d;
    mem_wdata_d = mem_we_d ? rd_r : '0;
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_START;
      pc_q        <= '0;
      ir_op_q     <= '0;
      ir_r_q      <= '0;
      ir_opnd_q   <= '0;
      flags_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_op_q     <= ir_op_d;
      ir_r_q      <= ir_r_d;
      ir_opnd_q   <= ir_opnd_d;
      flags_q     <= flags_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign halted    = halted_q;
  assign dbg_pc    = pc_q;
  assign dbg_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sap_core_param.sv
`default_nettype none
// ============================================================================
// tb_sap_core_param : program-table bench with memory model and OUT scoreboard
// Rev 1.0
// ============================================================================
module tb_sap_core_param;

  localparam logic [3:0] NOP = 4'h0, LDA = 4'h1, STA = 4'h2, LDI = 4'h3, ADD = 4'h4;
  localparam logic [3:0] SUB = 4'h5, JMP = 4'h7, JZ = 4'h8, JC = 4'h9, OUTI = 4'hA, HLT = 4'hF;
  localparam int NVEC = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [7:0]  mem_addr, dbg_pc;
  logic [15:0] mem_wdata, mem_rdata, out_data;
  logic        out_valid, halted;
  logic [2:0]  dbg_state;

  sap_core_param #(.DATA_W(16), .ADDR_W(8), .NUM_REGS(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .out_data(out_data), .out_valid(out_valid), .halted(halted),
    .dbg_pc(dbg_pc), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] r, input logic [7:0] a);
    return {op, r, 2'b00, a};
  endfunction

  // Memory model with programmable wait states
  logic [15:0] mem [256];
  int          waits = 0;
  int          wcnt = 0;
  logic        req_active = 1'b0;
  logic [7:0]  x_addr;
  logic        x_we;
  logic [15:0] x_wdata;
  int          wr_cnt = 0;
  logic [7:0]  last_wr_addr;
  logic [15:0] last_wr_data;
  int          stab_err = 0;
  logic [7:0]  fetch_log [$];

  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (mem_ready) begin
      if (!rst && x_we) begin
        mem[x_addr] = x_wdata;
        wr_cnt++;
        last_wr_addr = x_addr;
        last_wr_data = x_wdata;
      end
      mem_ready = 1'b0;
      wcnt = 0;
    end
    if (!rst && mem_req) begin
      if (req_active && (mem_addr !== x_addr || mem_we !== x_we || mem_wdata !== x_wdata))
        stab_err++;
      if (!req_active) begin
        req_active = 1'b1;
        x_addr = mem_addr;
        x_we = mem_we;
        x_wdata = mem_wdata;
      end
      if (wcnt >= waits) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
        req_active = 1'b0;
        if (dbg_state == 3'd1) fetch_log.push_back(mem_addr);
      end else begin
        wcnt++;
      end
    end else begin
      req_active = 1'b0;
      wcnt = 0;
    end
  end

  // OUT scoreboard
  logic [15:0] exp_q [$];
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 32'(out_data), 32'hDEAD_0000);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    int          waits;
    logic [7:0]  daddr;
    logic [15:0] dval;
    logic [15:0] exp_out;
    int          exp_cycles;
    int          exp_wr_cnt;
    logic [7:0]  exp_wr_addr;
    logic [15:0] exp_wr_data;
  } vec_t;

  vec_t        vecs [NVEC];
  logic [15:0] progs [NVEC][8];

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = '0;
  endtask

  task automatic run_vec(input int i);
    int n;
    rst = 1'b1;
    clear_mem();
    for (int k = 0; k < 8; k++) mem[k] = progs[i][k];
    mem[vecs[i].daddr] = vecs[i].dval;
    waits = vecs[i].waits;
    exp_q.delete();
    exp_q.push_back(vecs[i].exp_out);
    wr_cnt = 0;
    stab_err = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_cycles", i), 32'(n), 32'(vecs[i].exp_cycles + 1));
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_halt_req", i), {31'b0, mem_req}, 32'd0);
    check($sformatf("v%0d_out_left", i), 32'(exp_q.size()), 32'd0);
    check($sformatf("v%0d_stable", i), 32'(stab_err), 32'd0);
    check($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt), 32'(vecs[i].exp_wr_cnt));
    if (vecs[i].exp_wr_cnt > 0) begin
      check($sformatf("v%0d_wr_addr", i), 32'(last_wr_addr), 32'(vecs[i].exp_wr_addr));
      check($sformatf("v%0d_wr_data", i), 32'(last_wr_data), 32'(vecs[i].exp_wr_data));
    end
  endtask

  initial begin
    int n;
    progs[0] = '{ins(LDI,0,8'h05), ins(ADD,0,8'h20), ins(OUTI,0,0), ins(HLT,0,0), 0, 0, 0, 0};
    progs[1] = progs[0];
    progs[2] = '{ins(LDI,1,8'h02), ins(SUB,1,8'h21), ins(JC,0,8'h07), ins(JZ,0,8'h05),
                 ins(HLT,0,0), ins(OUTI,1,0), ins(HLT,0,0), ins(HLT,0,0)};
    progs[3] = '{ins(SUB,1,8'h22), ins(JZ,0,8'h07), ins(JC,0,8'h04), ins(HLT,0,0),
                 ins(OUTI,1,0), ins(HLT,0,0), 0, ins(HLT,0,0)};
    progs[4] = '{ins(LDA,2,8'h30), ins(STA,2,8'h40), ins(LDA,3,8'h40), ins(OUTI,3,0),
                 ins(HLT,0,0), 0, 0, 0};
    progs[5] = '{ins(LDI,0,8'h07), ins(4'hC,0,8'h55), ins(OUTI,0,0), ins(HLT,0,0), 0, 0, 0, 0};
    progs[6] = '{ins(LDA,0,8'h20), ins(ADD,0,8'h20), ins(JC,0,8'h04), ins(HLT,0,0),
                 ins(OUTI,0,0), ins(HLT,0,0), 0, 0};
    //            waits daddr  dval      out       cyc wr  waddr  wdata
    vecs[0] = '{0, 8'h20, 16'h0003, 16'h0008,   9, 0, 8'h00, 16'h0000};
    vecs[1] = '{3, 8'h20, 16'h0003, 16'h0008,  24, 0, 8'h00, 16'h0000};
    vecs[2] = '{0, 8'h21, 16'h0002, 16'h0000,  13, 0, 8'h00, 16'h0000};
    vecs[3] = '{0, 8'h22, 16'h0001, 16'hFFFF,  11, 0, 8'h00, 16'h0000};
    vecs[4] = '{1, 8'h30, 16'hBEEF, 16'hBEEF,  21, 1, 8'h40, 16'hBEEF};
    vecs[5] = '{0, 8'h20, 16'h0000, 16'h0007,   8, 0, 8'h00, 16'h0000};
    vecs[6] = '{0, 8'h20, 16'hFFFF, 16'hFFFE,  12, 0, 8'h00, 16'h0000};

    // Reset asserted mid-FETCH while the memory stalls
    clear_mem();
    waits = 100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_req", {31'b0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_req_async", {31'b0, mem_req}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_pc", 32'(dbg_pc), 32'd0);
    check("rst_outs", {28'b0, out_valid, halted, mem_we, mem_req}, 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_first_req_in_window", 32'((n >= 1) && (n <= 2)), 32'd1);
    check("rst_first_addr", 32'(mem_addr), 32'd0);

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // PC wrap through 0xFF
    rst = 1'b1;
    clear_mem();
    mem[8'h00] = ins(JMP, 0, 8'hFF);
    mem[8'hFF] = ins(NOP, 0, 8'h00);
    waits = 0;
    fetch_log.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("wrap_fetch_cnt_ge3", 32'(fetch_log.size() >= 3), 32'd1);
    if (fetch_log.size() >= 3) begin
      check("wrap_fetch0", 32'(fetch_log[0]), 32'h00);
      check("wrap_fetch1", 32'(fetch_log[1]), 32'hFF);
      check("wrap_fetch2", 32'(fetch_log[2]), 32'h00);
    end
    check("wrap_not_halted", {31'b0, halted}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
